// File: rtl/array_index_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_index_pkg
//  Description : Shared types and helpers for the array_index_writer block:
//                index-op encoding, FSM states, default dimensions and the
//                row-major linear address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package array_index_pkg;

    // Per-dimension index operation; codes 5-7 are reserved
    typedef enum logic [2:0] {
        OP_CUR      = 3'd0,
        OP_PRE_INC  = 3'd1,
        OP_POST_INC = 3'd2,
        OP_PRE_DEC  = 3'd3,
        OP_POST_DEC = 3'd4
    } idx_op_e;

    // Command sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IDX0 = 3'd1,
        S_IDX1 = 3'd2,
        S_IDX2 = 3'd3,
        S_RESP = 3'd4
    } state_e;

    localparam int DEF_D0 = 2;
    localparam int DEF_D1 = 3;
    localparam int DEF_D2 = 4;
    localparam int DEF_W  = 32;

    // Row-major linear address: i0*D1*D2 + i1*D2 + i2
    function automatic logic [31:0] lin_addr(
        input logic [31:0] i0,
        input logic [31:0] i1,
        input logic [31:0] i2,
        input logic [31:0] d1,
        input logic [31:0] d2
    );
        return (i0 * d1 * d2) + (i1 * d2) + i2;
    endfunction

endpackage : array_index_pkg
`default_nettype wire

// File: rtl/array_index_eval.sv
`default_nettype none
// ============================================================================
//  Module      : array_index_eval
//  Description : Combinational evaluation of one index expression: applies
//                the op's side effect to pos, yields the index value, its
//                range status against the dimension size and a reserved-op
//                flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_index_eval
    import array_index_pkg::*;
(
    input  logic [2:0]         op,
    input  logic signed [31:0] pos,
    input  logic signed [31:0] dim,
    output logic signed [31:0] index,
    output logic signed [31:0] next_pos,
    output logic               in_range,
    output logic               op_err
);

    // Apply pre/post increment/decrement; reserved codes behave as CUR
    always_comb begin
        index    = pos;
        next_pos = pos;
        op_err   = 1'b0;
        case (op)
            OP_CUR: begin
            end
            OP_PRE_INC: begin
                next_pos = pos + 32'sd1;
                index    = pos + 32'sd1;
            end
            OP_POST_INC: begin
                next_pos = pos + 32'sd1;
            end
            OP_PRE_DEC: begin
                next_pos = pos - 32'sd1;
                index    = pos - 32'sd1;
            end
            OP_POST_DEC: begin
                next_pos = pos - 32'sd1;
            end
            default: begin
                op_err = 1'b1;
            end
        endcase
    end

    assign in_range = (index >= 32'sd0) && (index < dim);

endmodule : array_index_eval
`default_nettype wire

// File: rtl/array_index_writer.sv
`default_nettype none
// ============================================================================
//  Module      : array_index_writer
//  Description : Sequenced writer into a D0 x D1 x D2 array. Each dimension's
//                index is evaluated in its own cycle against a shared signed
//                position register with pre/post inc/dec side effects. A
//                guard bit short-circuits evaluation. Independent registered
//                read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_index_writer
    import array_index_pkg::*;
#(
    parameter int D0 = DEF_D0,
    parameter int D1 = DEF_D1,
    parameter int D2 = DEF_D2,
    parameter int W  = DEF_W
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_guard,
    input  logic                          cmd_pos_set,
    input  logic signed [31:0]            cmd_pos,
    input  logic [2:0]                    cmd_op0,
    input  logic [2:0]                    cmd_op1,
    input  logic [2:0]                    cmd_op2,
    input  logic [W-1:0]                  cmd_data,
    output logic                          resp_valid,
    output logic                          resp_wrote,
    output logic                          resp_err,
    output logic signed [31:0]            resp_pos,
    input  logic                          rd_en,
    input  logic [$clog2(D0*D1*D2)-1:0]   rd_addr,
    output logic [W-1:0]                  rd_data
);

    localparam int c_DEPTH = D0 * D1 * D2;
    localparam int c_AW    = $clog2(c_DEPTH);

    state_e             r_state;
    state_e             w_state_next;
    logic signed [31:0] r_pos;
    logic [2:0]         r_op0, r_op1, r_op2;
    logic [W-1:0]       r_data;
    logic signed [31:0] r_idx0, r_idx1;
    logic               r_err;
    logic               r_wrote;
    logic [W-1:0]       r_mem [c_DEPTH];
    logic [W-1:0]       r_rd_data;

    logic               w_accept;
    logic [2:0]         w_op;
    logic signed [31:0] w_dim;
    logic signed [31:0] w_index;
    logic signed [31:0] w_next_pos;
    logic               w_in_range;
    logic               w_op_err;
    logic               w_commit;
    logic [31:0]        w_lin;
    logic [c_AW-1:0]    w_waddr;
    logic               w_rd_ok;
    logic               w_unused_lin;

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    // Select the op and dimension size for the dimension being evaluated
    always_comb begin
        w_op  = r_op0;
        w_dim = 32'(D0);
        case (r_state)
            S_IDX1: begin
                w_op  = r_op1;
                w_dim = 32'(D1);
            end
            S_IDX2: begin
                w_op  = r_op2;
                w_dim = 32'(D2);
            end
            default: begin
            end
        endcase
    end

    // Single evaluator shared by the three index cycles
    array_index_eval u_eval (
        .op       (w_op),
        .pos      (r_pos),
        .dim      (w_dim),
        .index    (w_index),
        .next_pos (w_next_pos),
        .in_range (w_in_range),
        .op_err   (w_op_err)
    );

    // The write happens only when all three indices are legal and no op was reserved
    assign w_commit     = (r_state == S_IDX2) && !r_err && !w_op_err && w_in_range;
    assign w_lin        = lin_addr(r_idx0, r_idx1, w_index, 32'(D1), 32'(D2));
    assign w_waddr      = w_lin[c_AW-1:0];
    assign w_unused_lin = ^w_lin[31:c_AW];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state: guarded commands walk IDX0..IDX2, unguarded go straight to RESP
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = cmd_guard ? S_IDX0 : S_RESP;
            S_IDX0:  w_state_next = S_IDX1;
            S_IDX1:  w_state_next = S_IDX2;
            S_IDX2:  w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Command capture, pos side effects, index latching and status accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos   <= '0;
            r_op0   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_data  <= '0;
            r_idx0  <= '0;
            r_idx1  <= '0;
            r_err   <= 1'b0;
            r_wrote <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // The pos load applies even when the guard short-circuits
                        if (cmd_pos_set) r_pos <= cmd_pos;
                        r_op0   <= cmd_op0;
                        r_op1   <= cmd_op1;
                        r_op2   <= cmd_op2;
                        r_data  <= cmd_data;
                        r_err   <= 1'b0;
                        r_wrote <= 1'b0;
                    end
                end
                S_IDX0: begin
                    r_pos  <= w_next_pos;
                    r_idx0 <= w_index;
                    r_err  <= r_err | w_op_err | !w_in_range;
                end
                S_IDX1: begin
                    r_pos  <= w_next_pos;
                    r_idx1 <= w_index;
                    r_err  <= r_err | w_op_err | !w_in_range;
                end
                S_IDX2: begin
                    r_pos   <= w_next_pos;
                    r_err   <= r_err | w_op_err | !w_in_range;
                    r_wrote <= w_commit;
                end
                default: begin
                end
            endcase
        end
    end

    // Array storage: every element resets to its own linear index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_DEPTH; k++) r_mem[k] <= W'(k);
        end else if (w_commit) begin
            r_mem[w_waddr] <= r_data;
        end
    end

    assign w_rd_ok = (32'(rd_addr) < 32'(c_DEPTH));

    // Registered read port; same-cycle write is not forwarded, so the old value returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_rd_data <= '0;
        else if (rd_en) r_rd_data <= w_rd_ok ? r_mem[rd_addr] : '0;
    end

    assign rd_data    = r_rd_data;
    assign resp_valid = (r_state == S_RESP);
    assign resp_wrote = (r_state == S_RESP) && r_wrote;
    assign resp_err   = (r_state == S_RESP) && r_err;
    assign resp_pos   = r_pos;

endmodule : array_index_writer
`default_nettype wire

// File: tb/tb_array_index_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_index_writer
//  Description : Self-checking bench for array_index_writer with directed
//                scenarios and randomized commands against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_array_index_writer;

    localparam int NE = 24;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_guard;
    logic        cmd_pos_set;
    logic signed [31:0] cmd_pos;
    logic [2:0]  cmd_op0, cmd_op1, cmd_op2;
    logic [31:0] cmd_data;
    logic        resp_valid, resp_wrote, resp_err;
    logic signed [31:0] resp_pos;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pos;
    int m_mem [NE];

    array_index_writer #(.D0(2), .D1(3), .D2(4), .W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_guard(cmd_guard), .cmd_pos_set(cmd_pos_set), .cmd_pos(cmd_pos),
        .cmd_op0(cmd_op0), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_wrote(resp_wrote), .resp_err(resp_err),
        .resp_pos(resp_pos),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_reset();
        m_pos = 0;
        for (int k = 0; k < NE; k++) m_mem[k] = k;
    endfunction

    // Evaluate a command with plain SystemVerilog semantics, left to right
    function automatic void m_exec(input bit g, input bit ps, input int cp,
                                   input bit [2:0] o0, input bit [2:0] o1, input bit [2:0] o2,
                                   input int d, output bit wr, output bit er, output int rp);
        bit [2:0] ops [3];
        int dims [3];
        int idx [3];
        ops  = '{o0, o1, o2};
        dims = '{2, 3, 4};
        wr = 1'b0;
        er = 1'b0;
        if (ps) m_pos = cp;
        if (g) begin
            for (int n = 0; n < 3; n++) begin
                case (ops[n])
                    3'd0: idx[n] = m_pos;
                    3'd1: begin m_pos = m_pos + 1; idx[n] = m_pos; end
                    3'd2: begin idx[n] = m_pos; m_pos = m_pos + 1; end
                    3'd3: begin m_pos = m_pos - 1; idx[n] = m_pos; end
                    3'd4: begin idx[n] = m_pos; m_pos = m_pos - 1; end
                    default: begin idx[n] = m_pos; er = 1'b1; end
                endcase
                if (idx[n] < 0 || idx[n] >= dims[n]) er = 1'b1;
            end
            if (!er) begin
                m_mem[(idx[0] * 3 + idx[1]) * 4 + idx[2]] = d;
                wr = 1'b1;
            end
        end
        rp = m_pos;
    endfunction

    function automatic int m_read(input int a);
        return (a < NE) ? m_mem[a] : 0;
    endfunction

    // Drive one command and observe its response; cyc = -1 if none within budget
    task automatic issue(input bit g, input bit ps, input int cp,
                         input bit [2:0] o0, input bit [2:0] o1, input bit [2:0] o2,
                         input int d, output int cyc, output logic wr, output logic er,
                         output int rp, output logic rdy_acc, output logic rdy_after);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_guard = g; cmd_pos_set = ps; cmd_pos = cp;
        cmd_op0 = o0; cmd_op1 = o1; cmd_op2 = o2; cmd_data = d;
        rdy_acc = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_data = ~d; cmd_pos = $urandom; cmd_op0 = 3'($urandom);
        cyc = -1; wr = 1'bx; er = 1'bx; rp = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                cyc = c; wr = resp_wrote; er = resp_err; rp = resp_pos;
                break;
            end
        end
        @(negedge clk);
        rdy_after = cmd_ready;
    endtask

    task automatic do_read(input int a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 5'(a);
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        cmd_valid = 0; cmd_guard = 0; cmd_pos_set = 0; cmd_pos = 0;
        cmd_op0 = 0; cmd_op1 = 0; cmd_op2 = 0; cmd_data = 0; rd_en = 0; rd_addr = 0;
        m_reset();
        #2;
        checks++;
        if ({cmd_ready, resp_valid, resp_wrote, resp_err} !== 4'b0000 || resp_pos !== 0 || rd_data !== 0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b wr=%b er=%b pos=%0d rd=%0d required all 0",
                     cmd_ready, resp_valid, resp_wrote, resp_err, resp_pos, rd_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready);
        end
        do_read(23, d);
        checks++;
        if (d !== 32'd23) begin errors++; $display("FAIL reset_elem23: got %0d required 23", d); end
        do_read(24, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL read_oob24: got %0d required 0", d); end
        do_read(5, d);
        repeat (3) @(negedge clk);
        checks++;
        if (rd_data !== 32'd5) begin errors++; $display("FAIL read_hold: got %0d required 5", rd_data); end
    endtask

    task automatic test_write_basic();
        int cyc, rp, erp; logic wr, er, ra, rf; bit ewr, eer; logic [31:0] d;
        m_exec(1, 1, 0, 3'd2, 3'd2, 3'd1, 100, ewr, eer, erp);
        issue(1, 1, 0, 3'd2, 3'd2, 3'd1, 100, cyc, wr, er, rp, ra, rf);
        checks++;
        if (cyc !== 4 || wr !== 1'b1 || er !== 1'b0 || rp !== 3 || ra !== 1'b1 || rf !== 1'b1) begin
            errors++;
            $display("FAIL write_basic: cyc=%0d wr=%b er=%b pos=%0d rdy=%b/%b required cyc=4 wr=1 er=0 pos=3 rdy=1/1",
                     cyc, wr, er, rp, ra, rf);
        end
        do_read(7, d);
        checks++;
        if (d !== 32'd100) begin errors++; $display("FAIL write_basic_elem7: got %0d required 100", d); end
    endtask

    task automatic test_out_of_range();
        int cyc, rp, erp; logic wr, er, ra, rf; bit ewr, eer; logic [31:0] d;
        m_exec(1, 1, 3, 3'd0, 3'd0, 3'd3, 77, ewr, eer, erp);
        issue(1, 1, 3, 3'd0, 3'd0, 3'd3, 77, cyc, wr, er, rp, ra, rf);
        checks++;
        if (cyc !== 4 || wr !== 1'b0 || er !== 1'b1 || rp !== 2) begin
            errors++;
            $display("FAIL out_of_range: cyc=%0d wr=%b er=%b pos=%0d required cyc=4 wr=0 er=1 pos=2",
                     cyc, wr, er, rp);
        end
        do_read(7, d);
        checks++;
        if (d !== 32'(m_read(7))) begin
            errors++; $display("FAIL out_of_range_elem7: got %0d required %0d", d, m_read(7));
        end
    endtask

    task automatic test_guard();
        int cyc, rp, erp; logic wr, er, ra, rf; bit ewr, eer;
        // Guarded-off pos load still applies
        m_exec(0, 1, 0, 3'd1, 3'd1, 3'd1, 9, ewr, eer, erp);
        issue(0, 1, 0, 3'd1, 3'd1, 3'd1, 9, cyc, wr, er, rp, ra, rf);
        checks++;
        if (cyc !== 1 || wr !== 1'b0 || er !== 1'b0 || rp !== 0 || rf !== 1'b1) begin
            errors++;
            $display("FAIL guard_load: cyc=%0d wr=%b er=%b pos=%0d rdy=%b required cyc=1 wr=0 er=0 pos=0 rdy=1",
                     cyc, wr, er, rp, rf);
        end
        m_exec(0, 0, 0, 3'd1, 3'd1, 3'd1, 9, ewr, eer, erp);
        issue(0, 0, 55, 3'd1, 3'd1, 3'd1, 9, cyc, wr, er, rp, ra, rf);
        checks++;
        if (cyc !== 1 || wr !== 1'b0 || er !== 1'b0 || rp !== 0 || rf !== 1'b1) begin
            errors++;
            $display("FAIL guard_skip: cyc=%0d wr=%b er=%b pos=%0d rdy=%b required cyc=1 wr=0 er=0 pos=0 rdy=1",
                     cyc, wr, er, rp, rf);
        end
    endtask

    // Read the target element in the commit cycle (old value) and the next (new value)
    task automatic test_collision();
        int erp, old; bit ewr, eer;
        old = m_read(1);
        m_exec(1, 1, 0, 3'd0, 3'd0, 3'd1, 55, ewr, eer, erp);
        @(negedge clk);
        cmd_valid = 1; cmd_guard = 1; cmd_pos_set = 1; cmd_pos = 0;
        cmd_op0 = 3'd0; cmd_op1 = 3'd0; cmd_op2 = 3'd1; cmd_data = 55;
        @(posedge clk);
        #1 cmd_valid = 0;
        repeat (3) @(negedge clk);
        rd_en = 1; rd_addr = 5'd1;
        @(negedge clk);
        checks++;
        if (rd_data !== 32'(old)) begin
            errors++; $display("FAIL collision_old: got %0d required %0d", rd_data, old);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_wrote !== 1'b1 || resp_err !== 1'b0 || resp_pos !== 1) begin
            errors++;
            $display("FAIL collision_resp: rv=%b wr=%b er=%b pos=%0d required rv=1 wr=1 er=0 pos=1",
                     resp_valid, resp_wrote, resp_err, resp_pos);
        end
        @(negedge clk);
        rd_en = 0;
        checks++;
        if (rd_data !== 32'd55 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL collision_new: got %0d ready=%b required 55 ready=1", rd_data, cmd_ready);
        end
    endtask

    task automatic test_reserved_op();
        int cyc, rp, erp; logic wr, er, ra, rf; bit ewr, eer; logic [31:0] d;
        m_exec(1, 1, 0, 3'd0, 3'd6, 3'd0, 999, ewr, eer, erp);
        issue(1, 1, 0, 3'd0, 3'd6, 3'd0, 999, cyc, wr, er, rp, ra, rf);
        checks++;
        if (cyc !== 4 || wr !== 1'b0 || er !== 1'b1 || rp !== 0) begin
            errors++;
            $display("FAIL reserved_op: cyc=%0d wr=%b er=%b pos=%0d required cyc=4 wr=0 er=1 pos=0", cyc, wr, er, rp);
        end
        do_read(0, d);
        checks++;
        if (d !== 32'(m_read(0))) begin
            errors++; $display("FAIL reserved_op_elem0: got %0d required %0d", d, m_read(0));
        end
    endtask

    task automatic test_random();
        int cyc, rp, erp, cp, ecyc, a; logic wr, er, ra, rf; bit ewr, eer, g, ps;
        bit [2:0] o0, o1, o2; int d; logic [31:0] rdv;
        for (int i = 0; i < 60; i++) begin
            g  = ($urandom_range(0, 5) != 0);
            ps = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0: cp = 32'h7fffffff;
                1: cp = 32'h80000000;
                default: cp = int'($urandom_range(0, 5)) - 1;
            endcase
            o0 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            o1 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            o2 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            d  = int'($urandom);
            m_exec(g, ps, cp, o0, o1, o2, d, ewr, eer, erp);
            ecyc = g ? 4 : 1;
            issue(g, ps, cp, o0, o1, o2, d, cyc, wr, er, rp, ra, rf);
            checks++;
            if (cyc !== ecyc || wr !== ewr || er !== eer || rp !== erp || ra !== 1'b1 || rf !== 1'b1) begin
                errors++;
                $display("FAIL random_cmd[%0d]: cyc=%0d wr=%b er=%b pos=%0d rdy=%b/%b required cyc=%0d wr=%b er=%b pos=%0d rdy=1/1",
                         i, cyc, wr, er, rp, ra, rf, ecyc, ewr, eer, erp);
            end
            if (i % 4 == 3) begin
                a = int'($urandom_range(0, 31));
                do_read(a, rdv);
                checks++;
                if (rdv !== 32'(m_read(a))) begin
                    errors++; $display("FAIL random_read[%0d]: got %0d required %0d", a, rdv, m_read(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, rp, erp, seen; logic wr, er, ra, rf; bit ewr, eer; logic [31:0] d;
        @(negedge clk);
        cmd_valid = 1; cmd_guard = 1; cmd_pos_set = 1; cmd_pos = 0;
        cmd_op0 = 3'd2; cmd_op1 = 3'd2; cmd_op2 = 3'd1; cmd_data = 32'hdead;
        @(posedge clk);
        #1 cmd_valid = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        m_reset();
        seen = 0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b required 0", cmd_ready); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
            if (c == 0) begin
                checks++;
                if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_after: got %b required 1", cmd_ready); end
            end
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_resp: resp pulses %0d required 0", seen); end
        do_read(7, d);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL rst_mid_elem7: got %0d required 7", d); end
        m_exec(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, ewr, eer, erp);
        issue(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, cyc, wr, er, rp, ra, rf);
        checks++;
        if (cyc !== 1 || rp !== 0) begin
            errors++; $display("FAIL rst_mid_pos: cyc=%0d pos=%0d required cyc=1 pos=0", cyc, rp);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] d;
        for (int a = 0; a < 32; a++) begin
            do_read(a, d);
            checks++;
            if (d !== 32'(m_read(a))) begin
                errors++; $display("FAIL sweep[%0d]: got %0d required %0d", a, d, m_read(a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_out_of_range();
        test_guard();
        test_collision();
        test_reserved_op();
        test_random();
        test_sweep();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_array_index_writer
`default_nettype wire
